// File: rtl/ram_ctrl_pkg.sv
// Shared sizes and owner-state encoding for the banked byte RAM arbiter.
// The address is {bank[4:0], offset[9:0]}; the RAM decodes both fields itself.
package ram_ctrl_pkg;

  localparam int BANK_BITS   = 5;
  localparam int OFFSET_BITS = 10;
  localparam int ADDR_W      = BANK_BITS + OFFSET_BITS;
  localparam int DATA_W      = 8;
  localparam int BURST_W     = 4;

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } owner_state_t;

endpackage

// File: rtl/rr_arb2_burst.sv
// Two-way round-robin arbiter with bounded ownership bursts; grants are combinational from req.
// No stall path: a grant means the access is taken this cycle, the loser keeps requesting.
module rr_arb2_burst
  import ram_ctrl_pkg::*;
#(
  parameter int BURST_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req0_i,
  input  logic req1_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  localparam logic [BURST_W-1:0] BurstMax = BURST_W'(BURST_MAX);

  owner_state_t       state_q, state_d;
  owner_state_t       gnt_state;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic               last_q, last_d;
  logic [1:0]         req;
  logic               gnt_vld;
  logic               gnt_id;
  logic               own;

  assign req = {req1_i, req0_i};

  always_comb begin
    gnt_vld   = 1'b0;
    gnt_id    = 1'b0;
    own       = (state_q == OWN1);
    last_d    = last_q;
    state_d   = IDLE;
    burst_d   = '0;
    gnt_state = OWN0;

    if (state_q == IDLE) begin
      // Prefer whoever did not own the RAM most recently.
      if (req[~last_q]) begin
        gnt_vld = 1'b1;
        gnt_id  = ~last_q;
      end else if (req[last_q]) begin
        gnt_vld = 1'b1;
        gnt_id  = last_q;
      end
    end else begin
      if (req[own] && ((burst_q < BurstMax) || !req[~own])) begin
        gnt_vld = 1'b1;
        gnt_id  = own;
      end else begin
        last_d = own;
        if (req[~own]) begin
          gnt_vld = 1'b1;
          gnt_id  = ~own;
        end
      end
    end

    if (gnt_vld) begin
      gnt_state = gnt_id ? OWN1 : OWN0;
      state_d   = gnt_state;
      if (state_q != gnt_state) begin
        burst_d = BURST_W'(1);
      end else if (burst_q < BurstMax) begin
        burst_d = burst_q + BURST_W'(1);
      end else begin
        burst_d = burst_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      burst_q <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      last_q  <= last_d;
    end
  end

  assign gnt0_o = gnt_vld & ~gnt_id & ~rst;
  assign gnt1_o = gnt_vld &  gnt_id & ~rst;

endmodule

// File: rtl/ram_arbiter_2p.sv
// Shares one byte RAM between CPU (0) and DMA (1) ports: same-cycle grant/mux, read data one cycle later.
// Losing requester simply holds req; no access is issued without a grant.
module ram_arbiter_2p
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W    = ram_ctrl_pkg::ADDR_W,
  parameter int DATA_W    = ram_ctrl_pkg::DATA_W,
  parameter int BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);

  logic              any_gnt;
  logic [ADDR_W-1:0] addr_sel, addr_q;
  logic [DATA_W-1:0] wdata_sel, wdata_q;
  logic              rvalid0_q, rvalid1_q;
  logic              rvalid0_d, rvalid1_d;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  rr_arb2_burst #(
    .BURST_MAX(BURST_MAX)
  ) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req0_i(req0),
    .req1_i(req1),
    .gnt0_o(gnt0),
    .gnt1_o(gnt1)
  );

  assign any_gnt   = gnt0 | gnt1;
  assign addr_sel  = gnt1 ? addr1 : addr0;
  assign wdata_sel = gnt1 ? wdata1 : wdata0;
  assign rvalid0_d = gnt0 & ~we0;
  assign rvalid1_d = gnt1 & ~we1;

  // Grants are already reset-gated, so ram_we can never pulse during reset.
  assign ram_we      = (gnt0 & we0) | (gnt1 & we1);
  assign ram_address = rst ? '0 : (any_gnt ? addr_sel : addr_q);
  assign ram_data_in = rst ? '0 : (any_gnt ? wdata_sel : wdata_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (any_gnt) begin
      addr_q  <= addr_sel;
      wdata_q <= wdata_sel;
    end
  end

  // RAM output is valid in the return cycle, so it is passed straight through and captured for holding.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      if (rvalid0_q) rdata0_q <= ram_data_out;
      if (rvalid1_q) rdata1_q <= ram_data_out;
    end
  end

  assign rvalid0 = rvalid0_q & ~rst;
  assign rvalid1 = rvalid1_q & ~rst;
  assign rdata0  = rst ? '0 : (rvalid0_q ? ram_data_out : rdata0_q);
  assign rdata1  = rst ? '0 : (rvalid1_q ? ram_data_out : rdata1_q);

endmodule
